// File: rtl/alu_pkg.sv
// Shared op-codes, FSM state type and iteration-counter sizing for alu_multicycle.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;

    typedef enum logic {StIdle, StRun} state_t;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// o_*_nxt expose the value the registers take on the next step so the caller can latch the final one.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_lo_nxt,
    output logic [WIDTH-1:0] o_hi_nxt,
    output logic             o_last
);
    localparam int unsigned CW = cnt_width(WIDTH);

    logic             r_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_mul;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;

    // Multiply: {r_hi,r_lo} is accumulator:multiplier. Divide: r_hi is remainder, r_lo quotient.
    always_comb begin
        w_add = {1'b0, r_hi} + {1'b0, r_opnd};
        w_mul = r_lo[0] ? w_add : {1'b0, r_hi};
        w_shl = {r_hi, r_lo[WIDTH-1]};
        w_ge  = w_shl >= {1'b0, r_opnd};
        w_sub = w_shl[WIDTH-1:0] - r_opnd;
        if (r_div) begin
            o_hi_nxt = w_ge ? w_sub : w_shl[WIDTH-1:0];
            o_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            o_hi_nxt = w_mul[WIDTH:1];
            o_lo_nxt = {w_mul[0], r_lo[WIDTH-1:1]};
        end
    end

    assign o_last = (r_cnt == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_div  <= i_div;
            r_hi   <= '0;
            r_lo   <= i_div ? i_a : i_b;
            r_opnd <= i_div ? i_b : i_a;
            r_cnt  <= CW'(WIDTH);
        end else if (i_step) begin
            r_hi  <= o_hi_nxt;
            r_lo  <= o_lo_nxt;
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle EX unit: single-cycle logic/arith ops plus iterative MULU/DIVU.
// MULU/DIVU and the RUN state exist only when ALU_MULDIV_EN is defined.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow
);
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_ovf;
    logic             r_done;

    logic [WIDTH-1:0] w_result_d;
    logic [WIDTH-1:0] w_hi_d;
    logic             w_zero_d;
    logic             w_ovf_d;
    logic             w_done_d;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_ovf;

    assign w_sum = a + b;
    assign w_dif = a - b;

    always_comb begin
        w_sc_res = '0;
        w_sc_ovf = 1'b0;
        case (op)
            OP_AND: w_sc_res = a & b;
            OP_OR:  w_sc_res = a | b;
            OP_ADD: begin
                w_sc_res = w_sum;
                w_sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_res = w_dif;
                w_sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: w_sc_res[0] = $signed(a) < $signed(b);
            default: ;
        endcase
    end

`ifdef ALU_MULDIV_EN
    state_t           r_state;
    state_t           w_state_d;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_md_hi;

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_div    (op == OP_DIVU),
        .i_a      (a),
        .i_b      (b),
        .o_lo_nxt (w_md_lo),
        .o_hi_nxt (w_md_hi),
        .o_last   (w_last)
    );

    always_comb begin
        w_state_d  = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_result_d = r_result;
        w_hi_d     = r_hi;
        w_zero_d   = r_zero;
        w_ovf_d    = r_ovf;
        w_done_d   = 1'b0;
        if (r_state == StRun) begin
            w_step = 1'b1;
            if (w_last) begin
                w_state_d  = StIdle;
                w_result_d = w_md_lo;
                w_hi_d     = w_md_hi;
                w_zero_d   = (w_md_lo == '0);
                w_ovf_d    = 1'b0;
                w_done_d   = 1'b1;
            end
        end else if (start) begin
            if (op == OP_MULU || op == OP_DIVU) begin
                w_load    = 1'b1;
                w_state_d = StRun;
            end else begin
                w_result_d = w_sc_res;
                w_hi_d     = '0;
                w_zero_d   = (w_sc_res == '0);
                w_ovf_d    = w_sc_ovf;
                w_done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_d;
    end

    assign busy = (r_state == StRun);
`else
    always_comb begin
        w_result_d = r_result;
        w_hi_d     = r_hi;
        w_zero_d   = r_zero;
        w_ovf_d    = r_ovf;
        w_done_d   = 1'b0;
        if (start) begin
            w_result_d = w_sc_res;
            w_hi_d     = '0;
            w_zero_d   = (w_sc_res == '0);
            w_ovf_d    = w_sc_ovf;
            w_done_d   = 1'b1;
        end
    end

    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_result <= w_result_d;
            r_hi     <= w_hi_d;
            r_zero   <= w_zero_d;
            r_ovf    <= w_ovf_d;
            r_done   <= w_done_d;
        end
    end

    assign result   = r_result;
    assign hi       = r_hi;
    assign zero     = r_zero;
    assign overflow = r_ovf;
    assign done     = r_done;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): per-cycle compare against a
// behavioural model plus directed literal checks. Tracks ALU_MULDIV_EN like the RTL.
module tb_alu_multicycle;
    localparam int unsigned W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, zero, overflow;
    logic [W-1:0] result, hi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_multicycle #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .hi       (hi),
        .zero     (zero),
        .overflow (overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the op-code table.
    function automatic logic [31:0] ref_lo(input logic [2:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
        logic [63:0] p;
        p = 64'(x) * 64'(y);
        case (o)
            3'b000: return x & y;
            3'b001: return x | y;
            3'b010: return x + y;
            3'b110: return x - y;
            3'b111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'b011: return MD ? p[31:0] : 32'd0;
            3'b100: return !MD ? 32'd0 : (y == 0) ? 32'hFFFF_FFFF : x / y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_hi(input logic [2:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
        logic [63:0] p;
        p = 64'(x) * 64'(y);
        case (o)
            3'b011: return MD ? p[63:32] : 32'd0;
            3'b100: return !MD ? 32'd0 : (y == 0) ? x : x % y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [2:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
        int    sx;
        int    sy;
        longint s;
        sx = x;
        sy = y;
        if (o == 3'b010)      s = longint'(sx) + longint'(sy);
        else if (o == 3'b110) s = longint'(sx) - longint'(sy);
        else                  return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Behavioural model: outputs expected after each edge.
    logic [31:0] e_result, e_hi, md_res, md_hi;
    logic        e_zero, e_ovf, e_done, e_busy;
    int          md_left;

    assign e_busy = (md_left != 0);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_result <= '0;
            e_hi     <= '0;
            e_zero   <= 1'b0;
            e_ovf    <= 1'b0;
            e_done   <= 1'b0;
            md_left  <= 0;
            md_res   <= '0;
            md_hi    <= '0;
        end else begin
            e_done <= 1'b0;
            if (md_left > 0) begin
                md_left <= md_left - 1;
                if (md_left == 1) begin
                    e_result <= md_res;
                    e_hi     <= md_hi;
                    e_zero   <= (md_res == 0);
                    e_ovf    <= 1'b0;
                    e_done   <= 1'b1;
                end
            end else if (start) begin
                if (MD && (op == 3'b011 || op == 3'b100)) begin
                    md_left <= W;
                    md_res  <= ref_lo(op, a, b);
                    md_hi   <= ref_hi(op, a, b);
                end else begin
                    e_result <= ref_lo(op, a, b);
                    e_hi     <= ref_hi(op, a, b);
                    e_zero   <= (ref_lo(op, a, b) == 0);
                    e_ovf    <= ref_ovf(op, a, b);
                    e_done   <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {63'd0, busy}, {63'd0, e_busy});
        chk("done", {63'd0, done}, {63'd0, e_done});
        chk("result", {32'd0, result}, {32'd0, e_result});
        chk("hi", {32'd0, hi}, {32'd0, e_hi});
        chk("zero", {63'd0, zero}, {63'd0, e_zero});
        chk("overflow", {63'd0, overflow}, {63'd0, e_ovf});
    end

    // Present a request; it is taken at the next rising edge if idle.
    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(name, {63'd0, seen}, 64'd1);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 15));
            1: begin
                case ($urandom_range(0, 3))
                    0: return 32'h7FFF_FFFF;
                    1: return 32'h8000_0000;
                    2: return 32'hFFFF_FFFF;
                    default: return 32'h0;
                endcase
            end
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit seen;

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);

        drive(3'b010, 32'h7FFF_FFFF, 32'h1);
        @(negedge clk);
        chk("add_result", {32'd0, result}, 64'h8000_0000);
        chk("add_ovf", {63'd0, overflow}, 64'd1);
        chk("add_done", {63'd0, done}, 64'd1);
        @(negedge clk);
        chk("add_done_drop", {63'd0, done}, 64'd0);
        chk("add_hold", {32'd0, result}, 64'h8000_0000);

        drive(3'b110, 32'd5, 32'd5);
        @(negedge clk);
        chk("sub_result", {32'd0, result}, 64'd0);
        chk("sub_zero", {63'd0, zero}, 64'd1);
        chk("sub_ovf", {63'd0, overflow}, 64'd0);

        drive(3'b111, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        chk("slt_neg", {32'd0, result}, 64'd1);
        drive(3'b111, 32'd1, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("slt_swap", {32'd0, result}, 64'd0);
        drive(3'b000, 32'h0000_FFFF, 32'h1);
        @(negedge clk);
        chk("and_result", {32'd0, result}, 64'd1);

        drive(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) cnt++;
        end
        chk("mulu_done_seen", {63'd0, seen}, 64'd1);
        chk("mulu_busy_cycles", 64'(cnt), MD ? 64'd32 : 64'd0);
        chk("mulu_hi", {32'd0, hi}, MD ? 64'hFFFF_FFFE : 64'd0);
        chk("mulu_lo", {32'd0, result}, MD ? 64'h1 : 64'd0);

        // Issued in the done cycle: must be taken at once.
        drive(3'b010, 32'd10, 32'd20);
        @(negedge clk);
        chk("b2b_result", {32'd0, result}, 64'd30);
        chk("b2b_done", {63'd0, done}, 64'd1);

        drive(3'b100, 32'd100, 32'd7);
        wait_done("divu_done_seen");
        chk("divu_q", {32'd0, result}, MD ? 64'd14 : 64'd0);
        chk("divu_r", {32'd0, hi}, MD ? 64'd2 : 64'd0);

        drive(3'b100, 32'h1234, 32'd0);
        wait_done("div0_done_seen");
        chk("div0_q", {32'd0, result}, MD ? 64'hFFFF_FFFF : 64'd0);
        chk("div0_r", {32'd0, hi}, MD ? 64'h1234 : 64'd0);

        drive(3'b011, 32'h0001_0000, 32'h0001_0003);
        repeat (3) @(negedge clk);
        drive(3'b010, 32'd1, 32'd1);
        wait_done("ign_done_seen");
        chk("ign_result", {32'd0, result}, MD ? 64'h0003_0000 : 64'd2);
        chk("ign_hi", {32'd0, hi}, MD ? 64'd1 : 64'd0);

        drive(3'b100, 32'hDEAD_BEEF, 32'h13);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rstmid_result", {32'd0, result}, 64'd0);
        chk("rstmid_hi", {32'd0, hi}, 64'd0);
        chk("rstmid_busy", {63'd0, busy}, 64'd0);
        chk("rstmid_done", {63'd0, done}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_no_done", {63'd0, done}, 64'd0);
        end
        drive(3'b011, 32'd3, 32'd4);
        wait_done("mul34_done_seen");
        chk("mul34_result", {32'd0, result}, MD ? 64'd12 : 64'd0);

        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) != 0);
            op    = 3'($urandom_range(0, 7));
            a     = rnd_opnd();
            b     = rnd_opnd();
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
